// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem arbiter slice.
// DMEM_ARB_RR_EN (see dmem_arb_pick) selects round-robin tie-break instead of fixed A priority.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } arb_state_e;

   typedef enum logic {
      SIDE_A = 1'b0,
      SIDE_B = 1'b1
   } arb_side_e;

   localparam logic [1:0]  OWNER_IDLE = 2'd0;
   localparam logic [1:0]  OWNER_A    = 2'd1;
   localparam logic [1:0]  OWNER_B    = 2'd2;

   localparam logic [31:0] DMEM_MEM_BYTES = 32'h0004_0000;
   localparam int unsigned DMEM_MAX_BURST = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational tie-break between the two requesters.
// DMEM_ARB_RR_EN defined: round-robin against last owner; undefined: A (CPU) wins ties.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic      i_a_req,
   input  logic      i_b_req,
   input  arb_side_e i_last,
   output arb_side_e o_pick
);

   always_comb begin
      o_pick = i_last;
      if (i_a_req && i_b_req) begin
`ifdef DMEM_ARB_RR_EN
         o_pick = (i_last == SIDE_A) ? SIDE_B : SIDE_A;
`else
         o_pick = SIDE_A;
`endif
      end else if (i_a_req) begin
         o_pick = SIDE_A;
      end else if (i_b_req) begin
         o_pick = SIDE_B;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: registered ownership FSM, lock/burst limit, out-of-range write guard.
// Tie-break mode chosen by DMEM_ARB_RR_EN inside dmem_arb_pick.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = DMEM_MAX_BURST,
   parameter logic [31:0] MEM_BYTES = DMEM_MEM_BYTES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_lock,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic [3:0]  a_we,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   output logic        a_err,
   input  logic        b_req,
   input  logic        b_lock,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   input  logic [3:0]  b_we,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic        b_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  owner
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   arb_state_e    r_state, w_state_nxt;
   arb_side_e     r_last, w_last_nxt, w_pick;
   logic [CW-1:0] r_burst_cnt, w_cnt_nxt, w_cnt_inc;
   logic          w_oor;
   logic [3:0]    w_sel_we;

   dmem_arb_pick u_pick (
      .i_a_req (a_req),
      .i_b_req (b_req),
      .i_last  (r_last),
      .o_pick  (w_pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_burst_cnt <= '0;
         r_last      <= SIDE_B;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_cnt_nxt;
         r_last      <= w_last_nxt;
      end
   end

   assign a_ack = (r_state == ST_OWN_A) && a_req;
   assign b_ack = (r_state == ST_OWN_B) && b_req;
   assign owner = r_state;

   // Limit is checked on the post-beat count so the owner gets exactly MAX_BURST acks.
   assign w_cnt_inc = ((a_ack || b_ack) && (r_burst_cnt != MAX_CNT)) ?
                      r_burst_cnt + 1'b1 : r_burst_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_inc;
      w_last_nxt  = r_last;
      unique case (r_state)
         ST_IDLE: begin
            if (a_req || b_req) begin
               w_state_nxt = (w_pick == SIDE_B) ? ST_OWN_B : ST_OWN_A;
               w_cnt_nxt   = '0;
               w_last_nxt  = w_pick;
            end
         end
         ST_OWN_A: begin
            if ((b_req && w_cnt_inc == MAX_CNT) || (!a_req && !a_lock)) begin
               w_cnt_nxt = '0;
               if (b_req) begin
                  w_state_nxt = ST_OWN_B;
                  w_last_nxt  = SIDE_B;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_OWN_B: begin
            if ((a_req && w_cnt_inc == MAX_CNT) || (!b_req && !b_lock)) begin
               w_cnt_nxt = '0;
               if (a_req) begin
                  w_state_nxt = ST_OWN_A;
                  w_last_nxt  = SIDE_A;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      w_sel_we  = '0;
      unique case (r_state)
         ST_OWN_A: begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            w_sel_we  = a_we;
         end
         ST_OWN_B: begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            w_sel_we  = b_we;
         end
         default: ;
      endcase
   end

   assign w_oor   = (mem_addr >= MEM_BYTES);
   assign mem_we  = (!reset && (a_ack || b_ack) && !w_oor) ? w_sel_we : '0;
   assign a_rdata = a_ack ? mem_rdata : '0;
   assign b_rdata = b_ack ? mem_rdata : '0;
   assign a_err   = a_ack && w_oor && (a_we != '0);
   assign b_err   = b_ack && w_oor && (b_we != '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-lane dmem model.
// Contention expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

   logic        clk, reset;
   logic        a_req, a_lock, b_req, b_lock;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [3:0]  a_we, b_we;
   logic        a_ack, b_ack, a_err, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;
   logic [1:0]  owner;

   logic [31:0] mem [0:255];
   int          n_vec = 0;
   int          n_err = 0;
   int          n_acks;

   dmem_arbiter #(.MAX_BURST(8), .MEM_BYTES(32'h0004_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_lock    (a_lock),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_we      (a_we),
      .a_ack     (a_ack),
      .a_rdata   (a_rdata),
      .a_err     (a_err),
      .b_req     (b_req),
      .b_lock    (b_lock),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_we      (b_we),
      .b_ack     (b_ack),
      .b_rdata   (b_rdata),
      .b_err     (b_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
      reset = 1'b1;
      a_req = 1'b1; a_lock = 1'b0; a_addr = 32'h100; a_wdata = 32'hDEADBEEF; a_we = 4'hF;
      b_req = 1'b0; b_lock = 1'b0; b_addr = '0;     b_wdata = '0;           b_we = 4'h0;

      // 1: reset holds everything quiet
      #1;
      check("rst_owner", owner, 2'd0);
      check("rst_mem_we", mem_we, 4'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_owner_hold", owner, 2'd0);
         check("rst_a_ack", a_ack, 1'b0);
         check("rst_mem_we_hold", mem_we, 4'h0);
      end
      reset = 1'b0;
      #1;
      check("rel_no_ack", a_ack, 1'b0);
      tick();
      check("grant_owner", owner, 2'd1);
      check("grant_a_ack", a_ack, 1'b1);
      check("wr_mem_we", mem_we, 4'hF);
      check("wr_mem_addr", mem_addr, 32'h100);

      // 2: write commits, read back, byte lane write
      tick();
      a_we = 4'h0;
      #1;
      check("rd_full", a_rdata, 32'hDEADBEEF);
      check("rd_mem_we", mem_we, 4'h0);
      a_we = 4'h2; a_wdata = 32'h0000_5500;
      tick();
      a_we = 4'h0;
      #1;
      check("rd_byte1", a_rdata, 32'hDEAD55EF);
      a_req = 1'b0;
      tick();
      check("release_idle", owner, 2'd0);

      // 3: simultaneous request from IDLE
      a_addr = 32'h100; b_addr = 32'h104; a_req = 1'b1; b_req = 1'b1;
      tick();
`ifdef DMEM_ARB_RR_EN
      check("tie_owner_rr", owner, 2'd2);
      check("tie_b_ack_rr", b_ack, 1'b1);
      check("tie_a_ack_rr", a_ack, 1'b0);
      check("tie_a_rdata_rr", a_rdata, 32'h0);
      b_req = 1'b0;
      tick();
      check("tie_hand_owner_rr", owner, 2'd1);
      check("tie_hand_a_ack_rr", a_ack, 1'b1);
`else
      check("tie_owner", owner, 2'd1);
      check("tie_a_ack", a_ack, 1'b1);
      check("tie_b_ack", b_ack, 1'b0);
      check("tie_b_rdata", b_rdata, 32'h0);
      check("tie_a_rdata", a_rdata, 32'hDEAD55EF);
      a_req = 1'b0;
      tick();
      check("tie_hand_owner", owner, 2'd2);
      check("tie_hand_b_ack", b_ack, 1'b1);
      check("tie_hand_b_rdata", b_rdata, 32'hA5A5_0041);
`endif
      a_req = 1'b0; b_req = 1'b0;
      tick();
      check("tie_idle", owner, 2'd0);

      // 4: locked burst is cut after 8 beats when B waits
      a_req = 1'b1; a_lock = 1'b1;
      tick();
      b_req = 1'b1;
      #1;
      n_acks = 0;
      for (int i = 0; i < 20; i++) begin
         if (owner != 2'd1) break;
         if (a_ack) n_acks++;
         tick();
      end
      check("burst_acks", n_acks, 32'd8);
      check("burst_owner_b", owner, 2'd2);
      check("burst_b_ack", b_ack, 1'b1);
      check("burst_a_ack", a_ack, 1'b0);
      b_req = 1'b0;
      tick();
      check("burst_regain", owner, 2'd1);
      check("burst_regain_ack", a_ack, 1'b1);
      a_req = 1'b0; a_lock = 1'b0;
      tick();
      check("burst_idle", owner, 2'd0);

      // 5: out-of-range write is suppressed
      b_req = 1'b1; b_addr = 32'h0004_0000; b_wdata = 32'h12345678; b_we = 4'hF;
      tick();
      check("oor_owner", owner, 2'd2);
      check("oor_b_ack", b_ack, 1'b1);
      check("oor_b_err", b_err, 1'b1);
      check("oor_mem_we", mem_we, 4'h0);
      b_req = 1'b0; b_we = 4'h0; a_req = 1'b1; a_addr = 32'h0; a_we = 4'h0;
      tick();
      check("oor_hand_owner", owner, 2'd1);
      check("oor_mem0", a_rdata, 32'hA5A5_0000);
      check("oor_a_err", a_err, 1'b0);

      // 6: async reset between edges during a write
      a_addr = 32'h100; a_we = 4'hF; a_wdata = 32'hCAFEF00D;
      #1;
      check("arst_pre_we", mem_we, 4'hF);
      #1 reset = 1'b1;
      #1;
      check("arst_owner", owner, 2'd0);
      check("arst_a_ack", a_ack, 1'b0);
      check("arst_mem_we", mem_we, 4'h0);
      @(posedge clk);
      #1;
      reset = 1'b0; a_we = 4'h0;
      tick();
      check("arst_regrant", owner, 2'd1);
      check("arst_kept", a_rdata, 32'hDEAD55EF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
